// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The CSUM state only exists when IMEM_LOADER_CSUM_EN is defined.
package imem_loader_pkg;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam int         IMEM_DEPTH = 4192;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
`ifdef IMEM_LOADER_CSUM_EN
        ST_CSUM,
`endif
        ST_DONE,
        ST_ERR
    } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words; word_valid pulses the cycle after lane 3.
// Latency: 1 cycle from the 4th byte to word_valid. Backpressure: none, consumes every byte_valid.
// The 2-bit lane counter restarts on clr (frame sync) or rst.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        last_lane,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [1:0] lane_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q     <= 2'd0;
            word_valid <= 1'b0;
            word_data  <= 32'd0;
        end else begin
            word_valid <= 1'b0;
            if (clr) begin
                lane_q <= 2'd0;
            end else if (byte_valid) begin
                word_data[{lane_q, 3'b000} +: 8] <= byte_data;
                lane_q                           <= lane_q + 2'd1;
                word_valid                       <= (lane_q == 2'd3);
            end
        end
    end

    assign last_lane = (lane_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Loads a framed byte stream (A5, LEN, data, CSUM if IMEM_LOADER_CSUM_EN) into instruction RAM and gates CPU reset.
// Latency: RAM write one cycle after a word's 4th byte; status one cycle after the deciding byte.
// Backpressure: none, in_ready is 1 whenever the block is out of reset.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          ram_we,
    output logic [AW-1:0] ram_waddr,
    output logic [31:0]   ram_wdata,
    output logic          cpu_rst_n,
    output logic          load_done,
    output logic          load_err
);

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    // State entered once the payload is exhausted.
`ifdef IMEM_LOADER_CSUM_EN
    localparam loader_state_t TAIL_ST = ST_CSUM;
`else
    localparam loader_state_t TAIL_ST = ST_DONE;
`endif

    loader_state_t state_q;
    loader_state_t state_d;

    logic [7:0]    len_lo_q;
    logic [15:0]   len_q;
    logic [AW-1:0] waddr_q;
    logic [15:0]   len_full;
    logic          accept;
    logic          is_sync;
    logic          sync_start;
    logic          data_byte;
    logic          last_lane;
    logic          last_word;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]    csum_q;
`endif

    assign accept     = in_valid && in_ready;
    assign is_sync    = (in_data == SYNC_BYTE);
    assign len_full   = {in_data, len_lo_q};
    assign data_byte  = accept && (state_q == ST_DATA);
    // A5 only resyncs outside a frame; inside DATA/CSUM it is payload.
    assign sync_start = accept && is_sync &&
                        ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
    assign last_word  = ((32'(waddr_q) + 32'd1) == 32'(len_q));

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (sync_start),
        .byte_valid (data_byte),
        .byte_data  (in_data),
        .last_lane  (last_lane),
        .word_valid (ram_we),
        .word_data  (ram_wdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (is_sync) state_d = ST_LEN_LO;
                end
                ST_LEN_LO: state_d = ST_LEN_HI;
                ST_LEN_HI: begin
                    if ({1'b0, len_full} > DEPTH_W) state_d = ST_ERR;
                    else if (len_full == 16'd0)     state_d = TAIL_ST;
                    else                            state_d = ST_DATA;
                end
                ST_DATA: begin
                    if (last_lane && last_word) state_d = TAIL_ST;
                end
`ifdef IMEM_LOADER_CSUM_EN
                ST_CSUM: state_d = (in_data == csum_q) ? ST_DONE : ST_ERR;
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        load_done = 1'b0;
        load_err  = 1'b0;
        cpu_rst_n = 1'b0;
        case (state_q)
            ST_DONE: begin
                load_done = 1'b1;
                cpu_rst_n = 1'b1;
            end
            ST_ERR:  load_err = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready <= 1'b0;
            len_lo_q <= 8'd0;
            len_q    <= 16'd0;
            waddr_q  <= '0;
        end else begin
            in_ready <= 1'b1;
            // Address advances after each write strobe; a new frame restarts at word 0.
            if (sync_start) begin
                waddr_q <= '0;
            end else if (ram_we) begin
                waddr_q <= waddr_q + 1'b1;
            end
            if (accept && (state_q == ST_LEN_LO)) len_lo_q <= in_data;
            if (accept && (state_q == ST_LEN_HI)) len_q    <= len_full;
        end
    end

`ifdef IMEM_LOADER_CSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            csum_q <= 8'd0;
        end else if (sync_start) begin
            csum_q <= 8'd0;
        end else if (data_byte) begin
            csum_q <= csum_q ^ in_data;
        end
    end
`endif

    assign ram_waddr = waddr_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed frames against a byte-position frame model plus literal pins.
module tb_imem_loader;

    localparam int DEPTH = 4192;
    localparam int AW    = 13;
`ifdef IMEM_LOADER_CSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    typedef logic [7:0] bq_t[$];

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [31:0]   ram_wdata;
    logic          cpu_rst_n;
    logic          load_done;
    logic          load_err;

    imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .cpu_rst_n (cpu_rst_n),
        .load_done (load_done),
        .load_err  (load_err)
    );

    initial forever #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Captured RAM image and write count.
    logic [31:0] mem [DEPTH];
    int          wr_count = 0;

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
            wr_count       <= wr_count + 1;
        end
    end

    // Frame model: tracks the byte position within the current frame.
    bit          m_started = 1'b0;
    bit          m_ready   = 1'b0;
    bit          m_rstv    = 1'b0;
    bit          m_we      = 1'b0;
    bit          m_done    = 1'b0;
    bit          m_err     = 1'b0;
    bit          m_cpu     = 1'b0;
    bit          m_in_frame = 1'b0;
    int          m_pos     = 0;
    int          m_len     = 0;
    int          m_waddr   = 0;
    logic [7:0]  m_xor     = 8'd0;
    logic [31:0] m_word    = 32'd0;
    logic [31:0] m_wdata   = 32'd0;

    task automatic finish_frame(input bit ok);
        m_in_frame = 1'b0;
        m_done     = ok;
        m_cpu      = ok;
        m_err      = !ok;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int di;
        int last;
        if (!m_in_frame) begin
            if (b == 8'hA5) begin
                m_in_frame = 1'b1;
                m_pos = 0; m_len = 0; m_xor = 8'd0;
                m_done = 1'b0; m_err = 1'b0; m_cpu = 1'b0;
            end
            return;
        end
        m_pos++;
        last = 2 + 4 * m_len;
        if (m_pos == 1) begin
            m_len = int'(b);
        end else if (m_pos == 2) begin
            m_len = m_len + 256 * int'(b);
            if (m_len > DEPTH) finish_frame(1'b0);
            else if (m_len == 0 && !CSUM_ON) finish_frame(1'b1);
        end else if (m_pos <= last) begin
            di = m_pos - 3;
            m_word[8 * (di % 4) +: 8] = b;
            m_xor = m_xor ^ b;
            if (di % 4 == 3) begin
                m_we    = 1'b1;
                m_waddr = di / 4;
                m_wdata = m_word;
            end
            if (m_pos == last && !CSUM_ON) finish_frame(1'b1);
        end else begin
            finish_frame(b == m_xor);
        end
    endtask

    always @(posedge clk) begin
        m_started = 1'b1;
        m_we      = 1'b0;
        if (rst) begin
            m_ready = 1'b0; m_rstv = 1'b1; m_in_frame = 1'b0;
            m_done = 1'b0; m_err = 1'b0; m_cpu = 1'b0;
        end else begin
            m_rstv = 1'b0;
            if (in_valid && m_ready) model_byte(in_data);
            m_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            check("in_ready", 32'(in_ready), 32'(m_ready));
            check("ram_we", 32'(ram_we), 32'(m_we));
            if (m_we) begin
                check("ram_waddr", 32'(ram_waddr), 32'(m_waddr));
                check("ram_wdata", ram_wdata, m_wdata);
            end
            if (m_rstv) begin
                check("rst_waddr", 32'(ram_waddr), 32'd0);
                check("rst_wdata", ram_wdata, 32'd0);
            end
            check("cpu_rst_n", 32'(cpu_rst_n), 32'(m_cpu));
            check("load_done", 32'(load_done), 32'(m_done));
            check("load_err", 32'(load_err), 32'(m_err));
        end
    end

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        idle(gap);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_seq(input bq_t s, input int maxgap);
        foreach (s[i]) send_byte(s[i], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
    endtask

    bq_t frame_a, frame_bad, frame_empty, frame_gap, frame_b, partial;
    int  pre;

    initial begin
        frame_a     = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        frame_bad   = frame_a;
        frame_empty = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00};
        frame_gap   = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h10, 8'h00};
        frame_b     = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        partial     = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
        if (CSUM_ON) begin
            frame_a.push_back(8'h90);
            frame_bad.push_back(8'h91);
            frame_empty.push_back(8'h00);
            frame_gap.push_back(8'hA6);
            frame_b.push_back(8'h22);
        end

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        rst = 1'b0;
        idle(2);
        check("ready_after_reset", 32'(in_ready), 32'd1);

        // Two-word frame with correct checksum.
        send_seq(frame_a, 0);
        idle(2);
        check("a_word0", mem[0], 32'h0000_0013);
        check("a_word1", mem[1], 32'h0010_0093);
        check("a_done", 32'(load_done), 32'd1);
        check("a_cpu_run", 32'(cpu_rst_n), 32'd1);
        check("a_no_err", 32'(load_err), 32'd0);

        if (CSUM_ON) begin
            mem[0] = 32'd0; mem[1] = 32'd0;
            send_seq(frame_bad, 0);
            idle(2);
            check("bad_word0", mem[0], 32'h0000_0013);
            check("bad_word1", mem[1], 32'h0010_0093);
            check("bad_err", 32'(load_err), 32'd1);
            check("bad_cpu_held", 32'(cpu_rst_n), 32'd0);
            check("bad_not_done", 32'(load_done), 32'd0);
        end

        // Leading junk then an empty frame.
        pre = wr_count;
        send_seq(frame_empty, 0);
        idle(2);
        check("empty_no_writes", 32'(wr_count - pre), 32'd0);
        check("empty_done", 32'(load_done), 32'd1);

        // Oversize length 4193 rejected right after the LEN_HI byte.
        send_byte(8'hA5, 0);
        send_byte(8'h61, 0);
        send_byte(8'h10, 0);
        check("oversize_err", 32'(load_err), 32'd1);
        check("oversize_cpu_held", 32'(cpu_rst_n), 32'd0);
        pre = wr_count;
        for (int i = 1; i <= 8; i++) send_byte(8'(i), 0);
        check("oversize_no_writes", 32'(wr_count - pre), 32'd0);
        mem[0] = 32'd0; mem[1] = 32'd0;
        send_seq(frame_a, 0);
        idle(2);
        check("recover_word1", mem[1], 32'h0010_0093);
        check("recover_done", 32'(load_done), 32'd1);

        // Random gaps with an A5 payload byte.
        send_seq(frame_gap, 3);
        idle(2);
        check("gap_word0", mem[0], 32'h0000_0013);
        check("gap_word1", mem[1], 32'h0010_00A5);
        check("gap_done", 32'(load_done), 32'd1);

        // Reset after 6 data bytes.
        send_seq(partial, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_ready", 32'(in_ready), 32'd0);
        check("midrst_we", 32'(ram_we), 32'd0);
        check("midrst_waddr", 32'(ram_waddr), 32'd0);
        check("midrst_wdata", ram_wdata, 32'd0);
        check("midrst_cpu", 32'(cpu_rst_n), 32'd0);
        check("midrst_done", 32'(load_done), 32'd0);
        check("midrst_err", 32'(load_err), 32'd0);
        rst = 1'b0;
        idle(2);
        send_seq(frame_a, 0);
        idle(2);
        check("post_rst_done", 32'(load_done), 32'd1);

        // Reload after DONE restarts at word 0.
        send_byte(8'hA5, 0);
        check("reload_cpu_held", 32'(cpu_rst_n), 32'd0);
        check("reload_done_clr", 32'(load_done), 32'd0);
        send_seq(frame_b, 1);
        idle(2);
        check("reload_word0", mem[0], 32'hDEAD_BEEF);
        check("reload_done", 32'(load_done), 32'd1);

        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
